led_blink_mon: RTL and testbench

LED_BLINK_MON -- requirements
Module: led_blink_mon

---
 rtl/led_blink_mon.sv | 145 ++++++++++++++
 tb/tb_led_blink_mon.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_mon.sv
// LED waveform monitor: measures rise-to-rise period and high time of an
// asynchronous LED signal, flags a stuck LED, and hands results out over valid/ready.
`timescale 1ns/1ps

module led_blink_mon #(
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = 200000000
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic             led_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             stuck_o,
    output logic             overrun_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             sync1;
    logic             sync2;
    logic             hist;
    logic             rise;
    logic             fall;
    logic             load;
    logic             cap;
    logic             pub;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_q;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= led_i;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;
    assign fall = ~sync2 & hist;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Edges take priority over the timeout in every state.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        cap       = 1'b0;
        pub       = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HIGH;
                    load      = 1'b1;
                end else if (cnt == TO) begin
                    state_nxt = STUCK;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nxt = LOW;
                    cap       = 1'b1;
                end else if (cnt == TO) begin
                    state_nxt = STUCK;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                    load      = 1'b1;
                    pub       = 1'b1;
                end else if (cnt == TO) begin
                    state_nxt = STUCK;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_nxt = HIGH;
                    load      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            high_q <= '0;
        end else begin
            if (load)           cnt <= ONE;
            else if (cnt != TO) cnt <= cnt + ONE;
            if (cap) high_q <= cnt;
        end
    end

    // Handshake: a result transfers on any cycle with valid_o & ready_i; the
    // held result stays stable until then, and a publish that finds it
    // unconsumed (ready_i low) is dropped with a one-cycle overrun_o pulse.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            period_o  <= '0;
            high_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (pub) begin
                if (!valid_o || ready_i) begin
                    period_o <= cnt;
                    high_o   <= high_q;
                    valid_o  <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign stuck_o = (state == STUCK);
    assign state_o = state;

endmodule

// File: tb/tb_led_blink_mon.sv
// Directed bench for led_blink_mon with TIMEOUT = 50: periodic waves,
// back-pressure, stuck detection, edge/timeout collision, reset and minimum period.
`timescale 1ns/1ps

module tb_led_blink_mon;

    localparam int W = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_STUCK = 2'd3;

    logic         clk100 = 1'b0;
    logic         rst_n;
    logic         led_i;
    logic         ready_i;
    logic [W-1:0] period_o;
    logic [W-1:0] high_o;
    logic         valid_o;
    logic         stuck_o;
    logic         overrun_o;
    logic [1:0]   state_o;

    int checks = 0;
    int errors = 0;

    int           tcnt, vcnt, ocnt, scnt, unstable, first_v;
    logic [W-1:0] last_p, last_h, prev_p, prev_h;
    logic         prev_v;

    led_blink_mon #(.CNT_W(W), .TIMEOUT(50)) dut (
        .clk100   (clk100),
        .rst_n    (rst_n),
        .led_i    (led_i),
        .period_o (period_o),
        .high_o   (high_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .stuck_o  (stuck_o),
        .overrun_o(overrun_o),
        .state_o  (state_o)
    );

    // clock / reset
    always #5 clk100 = ~clk100;

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic mon_clr();
        tcnt = 0; vcnt = 0; ocnt = 0; scnt = 0; unstable = 0; first_v = -1;
        last_p = '0; last_h = '0; prev_p = '0; prev_h = '0; prev_v = 1'b0;
    endtask

    // one clock, then sample outputs 1 ns after the edge
    task automatic tick();
        @(posedge clk100);
        #1;
        tcnt++;
        if (valid_o) begin
            vcnt++;
            if (first_v < 0) first_v = tcnt;
            last_p = period_o;
            last_h = high_o;
            if (prev_v && (period_o !== prev_p || high_o !== prev_h)) unstable++;
        end
        if (overrun_o) ocnt++;
        if (stuck_o) scnt++;
        prev_v = valid_o;
        prev_p = period_o;
        prev_h = high_o;
    endtask

    task automatic drive(input int hi, input int lo);
        led_i = 1'b1;
        repeat (hi) tick();
        led_i = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        rst_n = 1'b0; led_i = 1'b0; ready_i = 1'b1;
        mon_clr();
        repeat (2) @(posedge clk100);
        #1;
        check("rst_period", period_o, 0);
        check("rst_high", high_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_stuck", stuck_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_state", state_o, S_IDLE);
        rst_n = 1'b1;
        tick(); tick();

        // 10-cycle period, 4 high, always ready
        mon_clr();
        repeat (4) drive(4, 6);
        check("a_first_valid_cycle", first_v, 13);
        check("a_valid_cycles", vcnt, 3);
        check("a_period", last_p, 10);
        check("a_high", last_h, 4);
        check("a_overrun", ocnt, 0);
        check("a_stuck", scnt, 0);

        // consumer stalls for 25 cycles
        ready_i = 1'b0;
        mon_clr();
        drive(3, 5); drive(4, 6); drive(2, 5);
        check("b_valid_held", valid_o, 1);
        check("b_period_held", period_o, 10);
        check("b_high_held", high_o, 4);
        check("b_overrun_pulses", ocnt, 2);
        check("b_unstable", unstable, 0);
        check("b_first_valid_cycle", first_v, 3);
        ready_i = 1'b1;
        tick();
        check("b_accepted", valid_o, 0);

        // publish coinciding with valid & ready replaces the result
        ready_i = 1'b0;
        led_i = 1'b1;
        repeat (3) tick();
        check("c_valid", valid_o, 1);
        check("c_period", period_o, 8);
        check("c_high", high_o, 2);
        led_i = 1'b0;
        repeat (3) tick();
        led_i = 1'b1;
        repeat (2) tick();
        check("c_period_pre", period_o, 8);
        ready_i = 1'b1;
        tick();
        check("c_valid_reload", valid_o, 1);
        check("c_period_reload", period_o, 6);
        check("c_high_reload", high_o, 3);
        check("c_no_overrun", overrun_o, 0);
        tick();
        check("c_valid_drop", valid_o, 0);

        // LED held high -> stuck after cnt reaches 50
        repeat (48) tick();
        check("d_not_stuck_yet", stuck_o, 0);
        check("d_state_high", state_o, S_HIGH);
        tick();
        check("d_stuck", stuck_o, 1);
        check("d_state_stuck", state_o, S_STUCK);
        check("d_no_valid", valid_o, 0);
        led_i = 1'b0;
        repeat (5) tick();
        check("d_fall_ignored", state_o, S_STUCK);
        mon_clr();
        drive(4, 6); drive(4, 6);
        check("d_valid_count", vcnt, 1);
        check("d_period", last_p, 10);
        check("d_high", last_h, 4);
        check("d_stuck_clear", stuck_o, 0);
        check("d_state_low", state_o, S_LOW);

        // rise on the same cycle cnt hits TIMEOUT
        repeat (40) tick();
        led_i = 1'b1;
        repeat (2) tick();
        check("e_state_low", state_o, S_LOW);
        check("e_stuck_pre", stuck_o, 0);
        tick();
        check("e_state_high", state_o, S_HIGH);
        check("e_stuck_post", stuck_o, 0);
        check("e_valid", valid_o, 1);
        check("e_period", period_o, 50);
        check("e_high", high_o, 4);

        // asynchronous reset with valid_o = 1
        #2 rst_n = 1'b0;
        #1;
        check("f_rst_valid", valid_o, 0);
        check("f_rst_period", period_o, 0);
        check("f_rst_high", high_o, 0);
        check("f_rst_stuck", stuck_o, 0);
        check("f_rst_state", state_o, S_IDLE);
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("f_first_rise_high", state_o, S_HIGH);
        check("f_first_rise_novalid", valid_o, 0);
        // asynchronous reset during HIGH
        #2 rst_n = 1'b0;
        #1;
        check("f_rst2_state", state_o, S_IDLE);
        check("f_rst2_overrun", overrun_o, 0);
        led_i = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        mon_clr();
        drive(4, 6); drive(4, 6);
        check("f_first_valid_cycle", first_v, 13);
        check("f_valid_count", vcnt, 1);
        check("f_period", last_p, 10);
        check("f_high", last_h, 4);

        // minimum period: 3 cycles, 1 high
        mon_clr();
        repeat (6) drive(1, 2);
        check("g_first_valid_cycle", first_v, 3);
        check("g_valid_count", vcnt, 6);
        check("g_period", last_p, 3);
        check("g_high", last_h, 1);
        check("g_overrun", ocnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
